// File: rtl/sample_page_buffer.sv
// sample_page_buffer: ping-pong page buffer between an ADC sample stream and an
// I2C EEPROM page writer. One bank fills from samples while the other drains
// byte-by-byte with a valid/ready handshake and a running page start address.
module sample_page_buffer #(
    parameter int unsigned PAGE_BYTES = 32,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic              CLK_50MHz,
    input  logic              RESET,
    input  logic [7:0]        Sample_word,
    input  logic              Sample_valid,
    output logic [7:0]        Byte_out,
    output logic              Byte_valid,
    input  logic              Byte_ready,
    output logic              Page_first,
    output logic              Page_last,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic              Overrun
);

    localparam int unsigned     IDX_W    = $clog2(PAGE_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_BYTES - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} rd_state_t;

    logic [7:0]       bank_mem [2*PAGE_BYTES];
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       full;
    rd_state_t        state;
    logic             store;
    logic             page_done;

    // The full check uses the registered flag, so a bank freed on this edge
    // still rejects a sample arriving in the same cycle.
    assign store      = Sample_valid && !full[wr_bank];
    assign page_done  = (state == SEND) && Byte_ready && (rd_idx == LAST_IDX);
    assign Byte_valid = (state == SEND);

    // Sample storage; deliberately left out of reset.
    always_ff @(posedge CLK_50MHz) begin
        if (store) begin
            bank_mem[{wr_bank, wr_idx}] <= Sample_word;
        end
    end

    // Write-side index/bank advance and sticky overrun on a dropped sample.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            wr_bank <= 1'b0;
            wr_idx  <= '0;
            Overrun <= 1'b0;
        end else if (Sample_valid) begin
            if (full[wr_bank]) begin
                Overrun <= 1'b1;
            end else if (wr_idx == LAST_IDX) begin
                wr_idx  <= '0;
                wr_bank <= ~wr_bank;
            end else begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Bank full flags: set by the writer, cleared by the reader; the two
    // always address different banks, so both updates land on the same edge.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            full <= 2'b00;
        end else begin
            if (store && (wr_idx == LAST_IDX)) begin
                full[wr_bank] <= 1'b1;
            end
            if (page_done) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    // Read-side FSM with registered byte, page markers and page address.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            rd_bank    <= 1'b0;
            rd_idx     <= '0;
            Byte_out   <= 8'h00;
            Page_first <= 1'b0;
            Page_last  <= 1'b0;
            Mem_addr   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    Byte_out   <= bank_mem[{rd_bank, rd_idx}];
                    Page_first <= (rd_idx == '0);
                    Page_last  <= (rd_idx == LAST_IDX);
                    state      <= SEND;
                end
                SEND: begin
                    if (Byte_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_idx   <= '0;
                            rd_bank  <= ~rd_bank;
                            Mem_addr <= Mem_addr + ADDR_W'(PAGE_BYTES);
                            state    <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + IDX_W'(1);
                            state  <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_page_buffer.sv
// Self-checking bench for sample_page_buffer (PAGE_BYTES=32). A second
// instance with a 6-bit address shares all inputs to exercise address wrap.
module tb_sample_page_buffer;

    localparam int PB = 32;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    sample_word;
    logic          sample_valid;
    logic          byte_ready;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          page_first;
    logic          page_last;
    logic [AW-1:0] mem_addr;
    logic          overrun;

    logic [7:0]    s_byte_out;
    logic          s_byte_valid;
    logic          s_page_first;
    logic          s_page_last;
    logic [5:0]    s_mem_addr;
    logic          s_overrun;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic          rdy;
        logic          v;
        logic [7:0]    b;
        logic          f;
        logic          l;
        logic [AW-1:0] a;
    } vec_t;

    typedef struct {
        logic [7:0]    b;
        logic          f;
        logic          l;
        logic [AW-1:0] a;
    } obs_t;

    vec_t tbl [21];
    obs_t got [$];

    sample_page_buffer #(.PAGE_BYTES(PB), .ADDR_W(AW)) dut (
        .CLK_50MHz   (clk),
        .RESET       (rst),
        .Sample_word (sample_word),
        .Sample_valid(sample_valid),
        .Byte_out    (byte_out),
        .Byte_valid  (byte_valid),
        .Byte_ready  (byte_ready),
        .Page_first  (page_first),
        .Page_last   (page_last),
        .Mem_addr    (mem_addr),
        .Overrun     (overrun)
    );

    sample_page_buffer #(.PAGE_BYTES(PB), .ADDR_W(6)) dut_s (
        .CLK_50MHz   (clk),
        .RESET       (rst),
        .Sample_word (sample_word),
        .Sample_valid(sample_valid),
        .Byte_out    (s_byte_out),
        .Byte_valid  (s_byte_valid),
        .Byte_ready  (byte_ready),
        .Page_first  (s_page_first),
        .Page_last   (s_page_last),
        .Mem_addr    (s_mem_addr),
        .Overrun     (s_overrun)
    );

    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] v);
        sample_word  = v;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        byte_ready   = 1'b0;
        sample_word  = 8'h00;
        rst          = 1'b1;
        @(posedge clk);
        #5 rst = 1'b0;
        step();
    endtask

    // Collect n offered bytes with ready held high; stops before the final handshake edge.
    task automatic drain(input int n, input int budget);
        got.delete();
        byte_ready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (byte_valid) got.push_back('{byte_out, page_first, page_last, mem_addr});
            if (got.size() == n) break;
            step();
        end
        chk("drain_count", got.size(), n);
    endtask

    initial begin
        int   seen;
        logic found;
        logic [AW-1:0] last_a;
        logic [5:0]    last_s;
        int   ach [$];
        int   sch [$];

        // Stall/handshake table, starting the cycle after a page completes.
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0};
        tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0};
        for (int i = 2; i < 12; i++) tbl[i] = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 15'd32};
        tbl[12] = '{1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 15'd32};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0};
        tbl[14] = '{1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 15'd32};
        tbl[15] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 15'd32};
        tbl[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0};
        tbl[17] = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 15'd32};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 15'd0};
        tbl[19] = '{1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 15'd32};
        tbl[20] = '{1'b0, 1'b1, 8'h43, 1'b0, 1'b0, 15'd32};

        // Reset values while reset is asserted.
        rst = 1'b1; sample_valid = 1'b0; byte_ready = 1'b0; sample_word = 8'h00;
        #5;
        chk("rst_valid", byte_valid, 0);
        chk("rst_byte", byte_out, 0);
        chk("rst_first", page_first, 0);
        chk("rst_last", page_last, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_overrun", overrun, 0);
        @(posedge clk);
        #5 rst = 1'b0;
        step();

        // One page 0x00..0x1F with ready high: latency, order, markers, address.
        byte_ready = 1'b1;
        for (int i = 0; i < PB; i++) strobe(8'(i));
        chk("lat_cycle0", byte_valid, 0);
        step();
        chk("lat_cycle1", byte_valid, 0);
        step();
        chk("lat_cycle2", byte_valid, 1);
        chk("lat_byte", byte_out, 8'h00);
        drain(PB, 200);
        foreach (got[k]) begin
            chk("p0_byte", got[k].b, k);
            chk("p0_first", got[k].f, (k == 0));
            chk("p0_last", got[k].l, (k == PB - 1));
            chk("p0_addr", got[k].a, 0);
        end
        step();
        chk("p0_addr_after", mem_addr, 32);
        chk("p0_idle_valid", byte_valid, 0);

        // Second page with stalls applied from the table.
        byte_ready = 1'b0;
        for (int i = 0; i < PB; i++) strobe(8'(8'h40 + i));
        for (int i = 0; i < 21; i++) begin
            chk("tbl_valid", byte_valid, tbl[i].v);
            if (tbl[i].v) begin
                chk("tbl_byte", byte_out, tbl[i].b);
                chk("tbl_first", page_first, tbl[i].f);
                chk("tbl_last", page_last, tbl[i].l);
                chk("tbl_addr", mem_addr, tbl[i].a);
            end
            byte_ready = tbl[i].rdy;
            step();
        end
        drain(29, 200);
        foreach (got[k]) begin
            chk("p1_byte", got[k].b, 8'h43 + k);
            chk("p1_last", got[k].l, (k == 28));
        end
        step();
        chk("p1_addr_after", mem_addr, 64);

        // Both banks full with ready low; 65th sample dropped.
        do_reset();
        for (int i = 0; i < 64; i++) strobe(8'(i + 1));
        chk("ovr_before", overrun, 0);
        chk("ovr_stall_valid", byte_valid, 1);
        chk("ovr_stall_byte", byte_out, 1);
        strobe(8'd65);
        chk("ovr_set", overrun, 1);
        drain(64, 400);
        foreach (got[k]) begin
            chk("ovr_byte", got[k].b, k + 1);
            chk("ovr_addr", got[k].a, (k < 32) ? 0 : 32);
        end
        step();
        chk("ovr_sticky", overrun, 1);
        chk("ovr_addr_after", mem_addr, 64);
        seen = 0;
        repeat (6) begin
            step();
            if (byte_valid) seen++;
        end
        chk("ovr_no_extra", seen, 0);

        // Sample in the same cycle the reader frees the write bank.
        do_reset();
        for (int i = 0; i < 64; i++) strobe(8'(i + 1));
        chk("free_ovr_before", overrun, 0);
        byte_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (byte_valid && page_last) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("free_found_last", found, 1);
        chk("free_last_byte", byte_out, 32);
        sample_word  = 8'hAA;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        byte_ready   = 1'b0;
        chk("free_ovr_set", overrun, 1);
        strobe(8'hBB);
        for (int i = 0; i < 31; i++) strobe(8'(8'hC0 + i));
        drain(64, 400);
        if (got.size() == 64) begin
            chk("free_b1_first", got[0].b, 33);
            chk("free_b1_lastb", got[31].b, 64);
            chk("free_b1_addr", got[31].a, 32);
            chk("free_idx0_byte", got[32].b, 8'hBB);
            chk("free_idx0_first", got[32].f, 1);
            chk("free_idx0_addr", got[32].a, 64);
            chk("free_idx1_byte", got[33].b, 8'hC0);
            chk("free_end_byte", got[63].b, 8'hDE);
        end

        // Asynchronous reset while offering byte 5 of the second page.
        do_reset();
        byte_ready = 1'b1;
        for (int i = 0; i < 64; i++) strobe(8'(i));
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (byte_valid && byte_out == 8'd37) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("ar_found", found, 1);
        chk("ar_addr_before", mem_addr, 32);
        byte_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", byte_valid, 0);
        chk("ar_addr", mem_addr, 0);
        chk("ar_byte", byte_out, 0);
        chk("ar_first", page_first, 0);
        @(posedge clk);
        #5 rst = 1'b0;
        step();
        byte_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 31; i++) begin
            strobe(8'(8'h80 + i));
            if (byte_valid) seen++;
        end
        repeat (8) begin
            step();
            if (byte_valid) seen++;
        end
        chk("ar_no_early", seen, 0);
        strobe(8'h9F);
        drain(1, 10);
        if (got.size() == 1) begin
            chk("ar_new_byte", got[0].b, 8'h80);
            chk("ar_new_first", got[0].f, 1);
            chk("ar_new_addr", got[0].a, 0);
        end

        // Continuous strobes every 4 cycles, four pages; address wrap on the twin.
        do_reset();
        byte_ready = 1'b1;
        last_a = '0;
        last_s = '0;
        seen = 0;
        for (int c = 0; c < 700; c++) begin
            sample_valid = (c < 512) && (c % 4 == 0);
            sample_word  = 8'(c / 4);
            step();
            if (mem_addr != last_a) begin
                ach.push_back(int'(mem_addr));
                last_a = mem_addr;
            end
            if (s_mem_addr != last_s || (mem_addr != 0 && s_mem_addr == 0 && sch.size() < ach.size())) begin
                sch.push_back(int'(s_mem_addr));
                last_s = s_mem_addr;
            end
            if ({s_byte_valid, s_byte_out, s_page_first, s_page_last, s_overrun} !=
                {byte_valid, byte_out, page_first, page_last, overrun}) seen++;
        end
        sample_valid = 1'b0;
        chk("cont_overrun", overrun, 0);
        chk("cont_twin_diff", seen, 0);
        chk("cont_pages", ach.size(), 4);
        foreach (ach[i]) chk("cont_addr", ach[i], 32 * (i + 1));
        chk("cont_wrap_pages", sch.size(), 4);
        foreach (sch[i]) chk("cont_wrap_addr", sch[i], (32 * (i + 1)) % 64);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sample_page_buffer.md
SAMPLE_PAGE_BUFFER -- requirements
Module: sample_page_buffer

Interface
REQ-001 SHALL have parameter PAGE_BYTES, default 32, bytes per EEPROM page (power of 2, 2..128).
REQ-002 SHALL have parameter ADDR_W, default 15, EEPROM byte-address width.
REQ-003 SHALL have port CLK_50MHz  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Sample_word  input  8  ADC sample from the SPI ADC controller.
REQ-006 SHALL have port Sample_valid  input  1  one-cycle strobe; Sample_word is valid in that cycle.
REQ-007 SHALL have port Byte_out  output  8  byte offered to the I2C EEPROM controller.
REQ-008 SHALL have port Byte_valid  output  1  Byte_out is valid.
REQ-009 SHALL have port Byte_ready  input  1  EEPROM controller accepts Byte_out.
REQ-010 SHALL have port Page_first  output  1  Byte_out is byte 0 of a page.
REQ-011 SHALL have port Page_last  output  1  Byte_out is byte PAGE_BYTES-1 of a page.
REQ-012 SHALL have port Mem_addr  output  ADDR_W  EEPROM start address of the page being drained.
REQ-013 SHALL have port Overrun  output  1  sticky flag; a sample was dropped.

Function
REQ-014 SHALL hold two banks of PAGE_BYTES bytes (ping-pong): the write side fills one bank while the read side drains the other.
REQ-015 Write side SHALL keep wr_bank and wr_idx and, per bank, a registered full flag.
REQ-016 On Sample_valid with full[wr_bank]=0: store Sample_word at [wr_bank][wr_idx], then increment wr_idx.
REQ-017 On a store at wr_idx=PAGE_BYTES-1: set full[wr_bank], toggle wr_bank, and clear wr_idx to 0, all in the same edge.
REQ-018 On Sample_valid with full[wr_bank]=1: do not store the sample, set Overrun, and leave wr_idx and wr_bank unchanged.
REQ-019 Overrun SHALL remain 1 until RESET.
REQ-020 Read-side FSM states SHALL be IDLE, FETCH and SEND.
REQ-021 IDLE: when full[rd_bank]=1, go to FETCH; otherwise stay.
REQ-022 FETCH (one cycle): register Byte_out from [rd_bank][rd_idx], register Page_first=(rd_idx==0) and Page_last=(rd_idx==PAGE_BYTES-1), then go to SEND.
REQ-023 SEND: Byte_valid=1; Byte_out, Page_first, Page_last and Mem_addr SHALL stay stable until the cycle in which Byte_ready=1.
REQ-024 Byte_valid SHALL be 1 only in SEND.
REQ-025 SEND with Byte_ready=1 and not the last byte: increment rd_idx and go to FETCH.
REQ-026 SEND with Byte_ready=1 and the last byte: clear full[rd_bank], toggle rd_bank, clear rd_idx, add PAGE_BYTES to Mem_addr (modulo 2^ADDR_W), and go to IDLE.
REQ-027 Throughput SHALL be at most one byte per 2 cycles.
REQ-028 Latency from a bank becoming full to Byte_valid=1 SHALL be 2 cycles when the FSM is in IDLE (IDLE->FETCH->SEND).
REQ-029 Same-edge set of full[a] by the write side and clear of full[b] by the read side SHALL both take effect; a and b are always different banks.
REQ-030 A Sample_valid in the same cycle as the read side frees the bank at wr_bank SHALL be dropped with Overrun=1, since the full check uses the registered flag.
REQ-031 Mem_addr SHALL wrap from 2^ADDR_W-PAGE_BYTES to 0 with no flag.
REQ-032 Bank storage SHALL not be reset; only control state and outputs are reset.

Reset
REQ-033 While RESET=1, asynchronously: Byte_valid=0, Page_first=0, Page_last=0, Byte_out=0, Mem_addr=0, Overrun=0, full=2'b00, wr_bank=0, rd_bank=0, wr_idx=0, rd_idx=0, FSM=IDLE.
REQ-034 RESET mid-page (fill or drain) SHALL discard all buffered data; no byte SHALL be offered before 32 new samples are received (PAGE_BYTES=32).
REQ-035 The first edge after RESET deasserts SHALL act on inputs normally.

Verification
REQ-036 32 strobes of values 0x00..0x1F with Byte_ready=1 -> Byte_valid rises 2 cycles after the 32nd store; 32 bytes 0x00..0x1F out; Page_first on 0x00, Page_last on 0x1F; Mem_addr=0, then 32 after the last handshake.
REQ-037 Byte_ready held 0 for 10 cycles in SEND -> Byte_valid stays 1 and Byte_out, Page_first, Page_last and Mem_addr do not change; a single Byte_ready pulse transfers exactly one byte.
REQ-038 Byte_ready=0 throughout, 65 strobes -> both banks full; 65th sample dropped; Overrun=1 and stays 1; then draining yields samples 1..64 in order.
REQ-039 Continuous strobes every 4 cycles with Byte_ready=1 for 1024 pages (ADDR_W=15) -> no Overrun; Mem_addr sequence 0, 32, ..., 32736, 0.
REQ-040 RESET pulsed in SEND on byte 5 of a page -> Byte_valid=0 immediately (asynchronous); Mem_addr=0; next output is byte 0 of a freshly filled page.
REQ-041 Sample_valid in the exact cycle the read side frees the bank at wr_bank -> sample dropped, Overrun=1; the next strobe is stored at index 0 of that bank.
